// File: rtl/gpr_arb_pkg.sv
// Shared types and defaults for the two-requester GPR bus arbiter.
// Requester IDs double as the round-robin pointer encoding.
package gpr_arb_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_IDX_W    = 3;
  localparam int DEF_NUM_REGS = 8;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  function automatic logic other_id(input logic id);
    return (id == REQ_ID0) ? REQ_ID1 : REQ_ID0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie.
// On advance the pointer moves to whichever requester is not currently granted.
module rr_arbiter2
  import gpr_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_reg == REQ_ID0) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance && (gnt != 2'b00)) begin
      ptr_next = other_id(gnt[1] ? REQ_ID1 : REQ_ID0);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ptr_reg <= REQ_ID0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/gpr_bus_arbiter.sv
// Shares one GPR bank between two requesters: round-robin grant, a single
// read or write per access, one-hot SR/RA enables and a completion pulse.
module gpr_bus_arbiter
  import gpr_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                REQ0,
  input  logic                WE0,
  input  logic [IDX_W-1:0]    IDX0,
  input  logic [DATA_W-1:0]   WD0,
  output logic                ACK0,
  input  logic                REQ1,
  input  logic                WE1,
  input  logic [IDX_W-1:0]    IDX1,
  input  logic [DATA_W-1:0]   WD1,
  output logic                ACK1,
  output logic [DATA_W-1:0]   RDATA,
  output logic                ERR,
  output logic                GNT_ID,
  output logic                BUSY,
  output logic [NUM_REGS-1:0] SR,
  output logic [NUM_REGS-1:0] RA,
  output logic [DATA_W-1:0]   S_BUS,
  input  logic [DATA_W-1:0]   A_BUS
);

  localparam logic [IDX_W:0] NUM_REGS_X = (IDX_W+1)'(NUM_REGS);

  arb_state_e state_reg;
  arb_state_e state_next;

  logic [IDX_W-1:0]    idx_reg;
  logic                gnt_id_reg;
  logic                oor_reg;
  logic [DATA_W-1:0]   s_bus_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic [1:0]          arb_req;
  logic [1:0]          arb_gnt;
  logic                arb_advance;
  logic                take_grant;

  logic                sel_id;
  logic                sel_we;
  logic [IDX_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   sel_wd;
  logic                sel_oor;

  logic [NUM_REGS-1:0] hit;

  // In DONE the arbiter sees only the granted requester, so advancing moves
  // the pointer past it regardless of who is asking at that moment.
  always_comb begin
    arb_req = 2'b00;
    if (state_reg == ST_IDLE) begin
      arb_req = {REQ1, REQ0};
    end else if (state_reg == ST_DONE) begin
      arb_req = {gnt_id_reg == REQ_ID1, gnt_id_reg == REQ_ID0};
    end
  end

  assign arb_advance = (state_reg == ST_DONE);

  rr_arbiter2 u_rr (
    .CLK     (CLK),
    .CLR     (CLR),
    .req     (arb_req),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  assign take_grant = (state_reg == ST_IDLE) && (arb_gnt != 2'b00);
  assign sel_id     = arb_gnt[1] ? REQ_ID1 : REQ_ID0;
  assign sel_we     = (sel_id == REQ_ID1) ? WE1  : WE0;
  assign sel_idx    = (sel_id == REQ_ID1) ? IDX1 : IDX0;
  assign sel_wd     = (sel_id == REQ_ID1) ? WD1  : WD0;
  assign sel_oor    = ({1'b0, sel_idx} >= NUM_REGS_X);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (take_grant) begin
          state_next = sel_we ? ST_WR : ST_RD;
        end
      end
      ST_RD:   state_next = ST_DONE;
      ST_WR:   state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request latch; S_BUS is loaded at grant so it already carries WD during WR.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      idx_reg    <= '0;
      gnt_id_reg <= REQ_ID0;
      oor_reg    <= 1'b0;
      s_bus_reg  <= '0;
    end else if (take_grant) begin
      idx_reg    <= sel_idx;
      gnt_id_reg <= sel_id;
      oor_reg    <= sel_oor;
      if (sel_we && !sel_oor) begin
        s_bus_reg <= sel_wd;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rdata_reg <= '0;
    end else if (state_reg == ST_RD) begin
      rdata_reg <= oor_reg ? '0 : A_BUS;
    end
  end

  // Enables derive straight from the state register so reset drops them at once.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign hit[gi] = !oor_reg && (idx_reg == IDX_W'(gi));
      assign SR[gi]  = hit[gi] && (state_reg == ST_WR);
      assign RA[gi]  = hit[gi] && (state_reg == ST_RD);
    end
  endgenerate

  assign ACK0   = (state_reg == ST_DONE) && (gnt_id_reg == REQ_ID0);
  assign ACK1   = (state_reg == ST_DONE) && (gnt_id_reg == REQ_ID1);
  assign ERR    = (state_reg == ST_DONE) && oor_reg;
  assign GNT_ID = gnt_id_reg;
  assign BUSY   = (state_reg != ST_IDLE);
  assign S_BUS  = s_bus_reg;
  assign RDATA  = rdata_reg;

endmodule

// File: tb/tb_gpr_bus_arbiter.sv
// Bench for gpr_bus_arbiter: directed protocol cases, then random traffic from
// two requesters checked by a queue-based scoreboard against a shadow register file.
module tb_gpr_bus_arbiter;

  localparam int NR = 6;
  localparam int DW = 16;
  localparam int IW = 3;

  typedef struct {
    bit          we;
    int          idx;
    logic [DW-1:0] wd;
  } txn_t;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          REQ0, WE0, REQ1, WE1;
  logic [IW-1:0] IDX0, IDX1;
  logic [DW-1:0] WD0, WD1;
  logic          ACK0, ACK1, ERR, GNT_ID, BUSY;
  logic [DW-1:0] RDATA, S_BUS, A_BUS;
  logic [NR-1:0] SR, RA;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] bank   [NR];
  logic [DW-1:0] shadow [NR];
  logic [DW-1:0] rd_last;
  logic [DW-1:0] sbus_last;
  txn_t q0[$];
  txn_t q1[$];
  bit mon_en = 1'b0;

  always #5 CLK = ~CLK;

  gpr_bus_arbiter #(.NUM_REGS(NR), .DATA_W(DW), .IDX_W(IW)) dut (
    .CLK(CLK), .CLR(CLR),
    .REQ0(REQ0), .WE0(WE0), .IDX0(IDX0), .WD0(WD0), .ACK0(ACK0),
    .REQ1(REQ1), .WE1(WE1), .IDX1(IDX1), .WD1(WD1), .ACK1(ACK1),
    .RDATA(RDATA), .ERR(ERR), .GNT_ID(GNT_ID), .BUSY(BUSY),
    .SR(SR), .RA(RA), .S_BUS(S_BUS), .A_BUS(A_BUS)
  );

  // GPR bank model: captures on SR, drives A_BUS from the RA-selected register.
  always @(posedge CLK) begin
    for (int i = 0; i < NR; i++) if (SR[i]) bank[i] <= S_BUS;
  end

  always_comb begin
    A_BUS = 16'hDEAD;
    for (int i = 0; i < NR; i++) if (RA[i]) A_BUS = bank[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int idx);
    logic [NR-1:0] one;
    one = NR'(1);
    return (idx < NR) ? (one << idx) : '0;
  endfunction

  task automatic set_req(input int r, input bit rq, input bit we, input int idx, input logic [DW-1:0] wd);
    if (r == 0) begin
      REQ0 = rq; WE0 = we; IDX0 = IW'(idx); WD0 = wd;
    end else begin
      REQ1 = rq; WE1 = we; IDX1 = IW'(idx); WD1 = wd;
    end
  endtask

  // One access from an IDLE start; expectations come from the access rules and the shadow file.
  task automatic do_access(input int r, input bit we, input int idx, input logic [DW-1:0] wd, input bit withdraw);
    bit in_rng;
    in_rng = (idx < NR);
    set_req(r, 1'b1, we, idx, wd);
    @(negedge CLK);
    chk("idle_busy", BUSY, 0);
    @(negedge CLK);
    chk("acc_busy", BUSY, 1);
    chk("acc_gnt", GNT_ID, r);
    chk("acc_sr", SR, we ? oh(idx) : '0);
    chk("acc_ra", RA, we ? '0 : oh(idx));
    if (we && in_rng) sbus_last = wd;
    chk("acc_sbus", S_BUS, sbus_last);
    chk("acc_ack", {ACK1, ACK0}, 0);
    if (withdraw) set_req(r, 1'b0, ~we, idx ^ 1, ~wd);
    @(negedge CLK);
    chk("done_ack", {ACK1, ACK0}, (r == 1) ? 2'b10 : 2'b01);
    chk("done_err", ERR, !in_rng);
    if (!we) rd_last = in_rng ? shadow[idx] : '0;
    else if (in_rng) shadow[idx] = wd;
    chk("done_rdata", RDATA, rd_last);
    $display("access r%0d we=%0d idx=%0d wd=%h rdata=%h err=%0d", r, we, idx, wd, RDATA, ERR);
    @(posedge CLK);
    #1;
    set_req(r, 1'b0, 1'b0, 0, '0);
  endtask

  // Scoreboard monitor: tracks IDLE -> access -> DONE and pops the granted requester's queue.
  initial begin
    int   ms;
    bit   cur;
    bit   ptr_m;
    bit   in_rng;
    txn_t t;
    logic [DW-1:0] rd_m;
    ms = 0; cur = 1'b0; ptr_m = 1'b1; rd_m = '0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        case (ms)
          0: begin
            chk("m_idle_busy", BUSY, 0);
            chk("m_idle_ack", {ACK1, ACK0}, 0);
            chk("m_idle_rdata", RDATA, rd_m);
            if (REQ0 || REQ1) begin
              cur = (REQ0 && REQ1) ? ptr_m : REQ1;
              ms = 1;
            end
          end
          1: begin
            if ((cur ? q1.size() : q0.size()) == 0) begin
              chk("m_queue_empty", 1, 0);
              ms = 0;
            end else begin
              t = cur ? q1[0] : q0[0];
              in_rng = (t.idx < NR);
              chk("m_busy", BUSY, 1);
              chk("m_gnt", GNT_ID, cur);
              chk("m_sr", SR, t.we ? oh(t.idx) : '0);
              chk("m_ra", RA, t.we ? '0 : oh(t.idx));
              if (t.we && in_rng) chk("m_sbus", S_BUS, t.wd);
              chk("m_acc_ack", {ACK1, ACK0}, 0);
              chk("m_acc_rdata", RDATA, rd_m);
              ms = 2;
            end
          end
          default: begin
            t = cur ? q1.pop_front() : q0.pop_front();
            in_rng = (t.idx < NR);
            chk("m_ack", {ACK1, ACK0}, cur ? 2'b10 : 2'b01);
            chk("m_err", ERR, !in_rng);
            chk("m_sr_done", {SR, RA}, 0);
            if (!t.we) rd_m = in_rng ? shadow[t.idx] : '0;
            else if (in_rng) shadow[t.idx] = t.wd;
            chk("m_rdata", RDATA, rd_m);
            $display("txn r%0d we=%0d idx=%0d wd=%h rdata=%h err=%0d", cur, t.we, t.idx, t.wd, RDATA, ERR);
            ptr_m = !cur;
            ms = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gap [2];
    int   wait_c [2];
    bit   act [2];
    bit   ak [2];
    bit   b, g;
    txn_t cur_t [2];
    txn_t nt;

    // Reset held with a pending write: nothing may move.
    CLR = 1'b0;
    set_req(0, 1'b0, 1'b0, 0, '0);
    set_req(1, 1'b0, 1'b0, 0, '0);
    set_req(0, 1'b1, 1'b1, 5, 16'hA5C3);
    rd_last = '0;
    sbus_last = '0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_sr_ra", {SR, RA}, 0);
      chk("rst_sbus", S_BUS, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_ctl", {ACK0, ACK1, ERR, GNT_ID, BUSY}, 0);
    end
    CLR = 1'b1;
    @(negedge CLK);
    chk("rel_wr_sr", SR, oh(5));
    chk("rel_wr_sbus", S_BUS, 16'hA5C3);
    chk("rel_wr_ack", {ACK1, ACK0}, 0);
    @(negedge CLK);
    chk("rel_ack0", {ACK1, ACK0}, 2'b01);
    shadow[5] = 16'hA5C3;
    sbus_last = 16'hA5C3;
    @(posedge CLK);
    #1;
    set_req(0, 1'b0, 1'b0, 0, '0);

    for (int i = 0; i < 5; i++) do_access(i % 2, 1'b1, i, DW'($urandom), 1'b0);
    do_access(0, 1'b0, 5, '0, 1'b0);
    do_access(1, 1'b0, 7, '0, 1'b0);
    do_access(0, 1'b1, 6, 16'h1234, 1'b0);
    do_access(1, 1'b1, 2, 16'h5A5A, 1'b1);
    do_access(0, 1'b0, 2, '0, 1'b0);

    // Contention from reset: both writing, grants must alternate 0,1,0,1.
    CLR = 1'b0;
    rd_last = '0;
    sbus_last = '0;
    set_req(0, 1'b1, 1'b1, 1, 16'h1111);
    set_req(1, 1'b1, 1'b1, 3, 16'h3333);
    @(negedge CLK);
    CLR = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk("cont_ack0", ACK0, (k % 6) == 2);
      chk("cont_ack1", ACK1, (k % 6) == 5);
      chk("cont_busy", BUSY, (k % 3) != 0);
      if ((k % 3) != 0) chk("cont_gnt", GNT_ID, (k / 3) % 2);
      if ((k % 3) == 1) begin
        chk("cont_sr", SR, oh(((k / 3) % 2 == 1) ? 3 : 1));
        chk("cont_sbus", S_BUS, ((k / 3) % 2 == 1) ? 16'h3333 : 16'h1111);
      end
      $display("contention cycle %0d ack0=%0d ack1=%0d gnt=%0d", k, ACK0, ACK1, GNT_ID);
    end
    set_req(0, 1'b0, 1'b0, 0, '0);
    set_req(1, 1'b0, 1'b0, 0, '0);
    shadow[1] = 16'h1111;
    shadow[3] = 16'h3333;
    sbus_last = 16'h3333;
    @(posedge CLK);
    #1;

    // Reset during a read: abort, no ACK, pointer returns to requester 0.
    do_access(0, 1'b1, 4, 16'h4444, 1'b0);
    set_req(0, 1'b1, 1'b0, 1, '0);
    @(negedge CLK);
    chk("mid_idle", BUSY, 0);
    @(negedge CLK);
    chk("mid_rd_ra", RA, oh(1));
    #2;
    CLR = 1'b0;
    #1;
    chk("mid_rst_ra", {SR, RA}, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_ack", {ACK1, ACK0}, 0);
    set_req(0, 1'b0, 1'b0, 0, '0);
    @(negedge CLK);
    chk("mid_rst_hold_ack", {ACK1, ACK0}, 0);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    set_req(0, 1'b1, 1'b1, 0, 16'h0BEE);
    set_req(1, 1'b1, 1'b1, 5, 16'h5555);
    @(negedge CLK);
    chk("ptr_idle", BUSY, 0);
    @(negedge CLK);
    chk("ptr_gnt0", GNT_ID, 0);
    chk("ptr_sr", SR, oh(0));
    @(negedge CLK);
    chk("ptr_ack0", {ACK1, ACK0}, 2'b01);
    set_req(0, 1'b0, 1'b0, 0, '0);
    set_req(1, 1'b0, 1'b0, 0, '0);
    shadow[0] = 16'h0BEE;
    @(posedge CLK);
    #1;

    // Random traffic checked by the monitor.
    mon_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      gap[r] = $urandom_range(0, 2);
      wait_c[r] = 0;
      act[r] = 1'b0;
    end
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (cyc >= 700 && !act[0] && !act[1]) break;
      @(negedge CLK);
      ak[0] = ACK0;
      ak[1] = ACK1;
      b = BUSY;
      g = GNT_ID;
      @(posedge CLK);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (act[r]) begin
          if (ak[r]) begin
            act[r] = 1'b0;
            set_req(r, 1'b0, 1'b0, 0, '0);
            gap[r] = $urandom_range(0, 3);
          end else if (b && (g == r) && ($urandom_range(0, 3) == 0)) begin
            set_req(r, 1'b0, ~cur_t[r].we, cur_t[r].idx ^ 3, ~cur_t[r].wd);
            wait_c[r]++;
          end else if (++wait_c[r] > 40) begin
            chk("ack_timeout", r, 99);
            act[r] = 1'b0;
            set_req(r, 1'b0, 1'b0, 0, '0);
          end
        end
        if (!act[r]) begin
          if (gap[r] > 0) begin
            gap[r]--;
          end else if (cyc < 700) begin
            nt.we  = ($urandom_range(0, 1) == 1);
            nt.idx = $urandom_range(0, 7);
            nt.wd  = DW'($urandom);
            cur_t[r] = nt;
            if (r == 0) q0.push_back(nt);
            else q1.push_back(nt);
            set_req(r, 1'b1, nt.we, nt.idx, nt.wd);
            act[r] = 1'b1;
            wait_c[r] = 0;
          end
        end
      end
    end
    chk("drain_active", {act[1], act[0]}, 0);
    repeat (3) @(negedge CLK);
    chk("drain_queues", q0.size() + q1.size(), 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpr_bus_arbiter.md
Name: gpr_bus_arbiter

Overview:
- Shares one bank of NUM_REGS GPRs between two requesters (e.g. ALU writeback, load/store unit) over the common S_bus and A-bus.
- Arbitrates round-robin and generates the one-hot SR (store) and RA (register-to-A-bus) enables for the bank.
- Sequences each access as a single-register read or write, then returns an acknowledge.
- Sits between the datapath control and the GPR instances; the DE2-115 interface wrapper drives it from KEY/SW for board bring-up.

Parameters:
- NUM_REGS, 8, number of GPRs in the bank (2..16)
- DATA_W, 16, GPR data width
- IDX_W, 3, register index width (must satisfy 2**IDX_W >= NUM_REGS)

Ports:
- CLK  in  1  system clock, rising edge
- CLR  in  1  asynchronous active-low reset; CLR=0 clears all state immediately
- REQ0  in  1  requester 0 access request
- WE0  in  1  requester 0 op: 1=write, 0=read
- IDX0  in  IDX_W  requester 0 register index
- WD0  in  DATA_W  requester 0 write data
- ACK0  out  1  requester 0 completion pulse
- REQ1, WE1, IDX1, WD1, ACK1  same as above for requester 1
- RDATA  out  DATA_W  read result, valid in the ACK cycle of a read
- ERR  out  1  pulses with ACK when index >= NUM_REGS
- GNT_ID  out  1  requester currently being served
- BUSY  out  1  high in any state other than IDLE
- SR  out  NUM_REGS  one-hot store enable to GPR bank
- RA  out  NUM_REGS  one-hot A-bus enable to GPR bank
- S_BUS  out  DATA_W  write data to GPR bank
- A_BUS  in  DATA_W  data from GPR bank (driven by the RA-selected register)

Behaviour:
- Reset (CLR=0, async):
  - State=IDLE; round-robin pointer=0 (requester 0 favoured).
  - SR=0, RA=0, S_BUS=0, RDATA=0, ACK0=ACK1=0, ERR=0, GNT_ID=0, BUSY=0.
- FSM states: IDLE, RD, WR, DONE. Every transition takes one CLK.
- IDLE:
  - If any REQ is high, select the winner.
  - Exactly one REQ high: that requester wins.
  - Both high: the requester named by the pointer wins.
  - Latch the winner's WE, IDX and WD, set GNT_ID, then go to WR if WE=1, else to RD.
  - No REQ: remain in IDLE.
- WR:
  - SR[idx]=1 for exactly this cycle; S_BUS=latched WD.
  - The GPR captures on the rising edge that ends WR. Next state DONE.
- RD:
  - RA[idx]=1 for exactly this cycle.
  - RDATA is registered from A_BUS on the rising edge that ends RD. Next state DONE.
- DONE:
  - ACK of the granted requester is 1 for one cycle; ERR=1 in the same cycle if idx was out of range.
  - Pointer is set to the other requester. Next state IDLE.
- Outside WR and RD: SR=0 and RA=0. S_BUS holds its last value.
- SR and RA are never asserted in the same cycle. At most one bit of each is set.
- Out-of-range idx (>= NUM_REGS):
  - No SR/RA bit is asserted; S_BUS is not updated.
  - RDATA=0 for a read.
  - The normal WR/RD timing and the ACK still occur.
- Latency: IDLE sampling REQ to ACK is 3 cycles. Back-to-back throughput is one access per 3 cycles.
- Handshake:
  - A requester holds REQ, WE, IDX and WD stable until its ACK.
  - It must drop REQ in the cycle after ACK. REQ still high in that IDLE cycle counts as a new request.
  - Once latched, a transaction completes even if REQ drops mid-access.
  - The non-granted requester waits; its ACK stays 0.
- Fairness: with both REQs continuously high, grants alternate 0,1,0,1...
- RDATA holds its value until the next read completes. Writes do not change RDATA.
- Reset asserted mid-RD/WR: the access is aborted. SR/RA drop immediately (async) and no ACK is issued. The requester must re-request after reset release.

Decomposition:
- Package gpr_arb_pkg:
  - FSM state enum (IDLE, RD, WR, DONE).
  - Default widths DATA_W=16, IDX_W=3, NUM_REGS=8.
  - Requester ID constants REQ_ID0=0, REQ_ID1=1.
- Sub-module rr_arbiter2:
  - 2-input round-robin arbiter holding the pointer flop.
  - Ports: CLK, CLR, req[1:0], advance, gnt[1:0].
- Top level: FSM, request latch, one-hot decoder and RDATA register.

Test Plan:
- Reset: hold CLR=0 with REQ0=1 -> all outputs 0 and no ACK; release CLR -> first ACK0 exactly 3 cycles later.
- Write then read:
  - REQ0, WE0=1, IDX0=5, WD0=16'hA5C3 -> SR=8'b0010_0000 for one cycle with S_BUS=16'hA5C3; ACK0 on cycle 3.
  - Then read IDX0=5 -> RA=8'b0010_0000 for one cycle; RDATA=16'hA5C3 with ACK0.
- Contention: REQ0 and REQ1 held high from reset, both writing -> grant order 0,1,0,1; ACK0 and ACK1 each every 6 cycles, never in the same cycle.
- Out-of-range: NUM_REGS=6, REQ1 read IDX1=7 -> RA=0 and SR=0 throughout; RDATA=16'h0000, ACK1=1 and ERR=1 on cycle 3.
- Withdrawal: REQ1 write IDX1=2, REQ1 dropped in the WR cycle -> SR[2] still pulses and ACK1 is still issued.
- Mid-op reset: CLR=0 during RD -> RA goes to 0 asynchronously, no ACK, BUSY=0, pointer back to requester 0.
